// File: rtl/io_word_packer_pkg.sv
// Shared constants and helpers for the IO word packer.
//   IO_W_DEFAULT : beat width of the IO-pad data path
//   PATCH_W      : query patch word width
//   LEAF_W       : leaf / best-array word width
//   ceil_div     : integer ceiling division, used to derive the beat count
package io_word_packer_pkg;

  localparam int unsigned IO_W_DEFAULT = 11;
  localparam int unsigned PATCH_W      = 55;
  localparam int unsigned LEAF_W       = 64;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Wrap-at-COUNT beat counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one, wrapping to 0 after COUNT-1
//   clear      : synchronous return to 0, overrides inc
//   cnt        : current count
//   last       : cnt is at COUNT-1
module beat_counter #(
  parameter int unsigned  COUNT = 5,
  localparam int unsigned CW    = $clog2(COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LastVal = CW'(COUNT - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  assign cnt  = cnt_q;
  assign last = (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_word_packer.sv
// Width converter between narrow IO beats and wide internal words.
// Two independent paths sharing only clock, reset and flush:
//   pack   : in_valid/in_ready/in_data beats -> word_valid/word_ready/word_data
//   unpack : wr_valid/wr_ready/wr_data words -> out_valid/out_ready/out_data beats
//   flush  : synchronous abort of both paths (priority over all handshakes)
//   pack_cnt : beats accepted so far for the word being assembled
// Chunk c is word bits [c*IO_W +: IO_W], clipped at WORD_W. Beat k carries chunk k,
// or chunk BEATS-1-k when MSB_FIRST is set.
module io_word_packer
  import io_word_packer_pkg::*;
#(
  parameter int unsigned  IO_W      = IO_W_DEFAULT,
  parameter int unsigned  WORD_W    = PATCH_W,
  parameter bit           MSB_FIRST = 1'b0,
  localparam int unsigned BEATS     = ceil_div(WORD_W, IO_W),
  localparam int unsigned CNT_W     = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  // pack side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IO_W-1:0]   in_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  // unpack side
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IO_W-1:0]   out_data,
  output logic [CNT_W-1:0]  pack_cnt
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BEATS - 1);

  // ---------------------------------------------------------------------------
  // Pack path
  // ---------------------------------------------------------------------------
  logic              in_hs;
  logic              pack_last;
  logic [CNT_W-1:0]  pack_chunk;
  logic [WORD_W-1:0] pack_d, pack_q;
  logic              word_valid_d, word_valid_q;

  // A held word blocks new beats unless it leaves this cycle.
  assign in_ready   = !flush && (!word_valid_q || word_ready);
  assign in_hs      = in_valid && in_ready;
  assign pack_chunk = MSB_FIRST ? (LastIdx - pack_cnt) : pack_cnt;
  assign word_valid = word_valid_q;
  assign word_data  = pack_q;

  beat_counter #(
    .COUNT (BEATS)
  ) u_pack_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_hs),
    .clear (flush),
    .cnt   (pack_cnt),
    .last  (pack_last)
  );

  // The assembly register doubles as the output word; it is only written while
  // no word is held or the held word is being handed off this cycle.
  always_comb begin
    pack_d = pack_q;
    if (in_hs) begin
      for (int b = 0; b < WORD_W; b++) begin
        if (pack_chunk == CNT_W'(b / IO_W)) begin
          pack_d[b] = in_data[b % IO_W];
        end
      end
    end
  end

  always_comb begin
    word_valid_d = word_valid_q;
    if (flush) begin
      word_valid_d = 1'b0;
    end else if (in_hs && pack_last) begin
      word_valid_d = 1'b1;
    end else if (word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Unpack path
  // ---------------------------------------------------------------------------
  logic              wr_hs;
  logic              out_hs;
  logic              unpack_last;
  logic [CNT_W-1:0]  unpack_idx;
  logic [CNT_W-1:0]  out_chunk;
  logic [WORD_W-1:0] unpack_q;
  logic              out_valid_d, out_valid_q;

  // A new word may land while the last beat of the current one is leaving.
  assign wr_ready  = !flush && (!out_valid_q || (out_ready && unpack_last));
  assign wr_hs     = wr_valid && wr_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign out_chunk = MSB_FIRST ? (LastIdx - unpack_idx) : unpack_idx;
  assign out_valid = out_valid_q;

  beat_counter #(
    .COUNT (BEATS)
  ) u_unpack_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs),
    .clear (flush || wr_hs),
    .cnt   (unpack_idx),
    .last  (unpack_last)
  );

  // Bits of the top chunk above WORD_W stay at the zero default.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < WORD_W; b++) begin
      if (out_chunk == CNT_W'(b / IO_W)) begin
        out_data[b % IO_W] = unpack_q[b];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (wr_hs) begin
      out_valid_d = 1'b1;
    end else if (out_hs && unpack_last) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q       <= '0;
      word_valid_q <= 1'b0;
      unpack_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      pack_q       <= pack_d;
      word_valid_q <= word_valid_d;
      out_valid_q  <= out_valid_d;
      if (wr_hs) begin
        unpack_q <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_io_word_packer.sv
// Scoreboard bench for io_word_packer. Three instances:
//   0: IO_W=11 WORD_W=55 MSB_FIRST=0
//   1: IO_W=11 WORD_W=32 MSB_FIRST=0
//   2: IO_W=11 WORD_W=55 MSB_FIRST=1
// Per instance a monitor keeps a reference model (beat list -> word, word -> beat list)
// and compares every cycle on the falling edge.
module tb_io_word_packer;

  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush      [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [10:0] in_data    [3];
  logic        word_valid [3];
  logic        word_ready [3];
  logic [54:0] word_data  [3];
  logic        wr_valid   [3];
  logic        wr_ready   [3];
  logic [54:0] wr_data    [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [10:0] out_data   [3];
  logic [2:0]  pack_cnt   [3];
  logic [31:0] wd1;
  logic [1:0]  pc1;
  int          pr_mode    [3];  // word_ready: 0 high, 1 random, 2 low
  int          ur_mode    [3];  // out_ready:  same encoding

  int checks   = 0;
  int failures = 0;

  assign word_data[1] = {23'b0, wd1};
  assign pack_cnt[1]  = {1'b0, pc1};

  always #5 clk = ~clk;

  io_word_packer #(.IO_W(11), .WORD_W(55), .MSB_FIRST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .word_valid(word_valid[0]), .word_ready(word_ready[0]), .word_data(word_data[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .pack_cnt(pack_cnt[0])
  );

  io_word_packer #(.IO_W(11), .WORD_W(32), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .word_valid(word_valid[1]), .word_ready(word_ready[1]), .word_data(wd1),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1][31:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .pack_cnt(pc1)
  );

  io_word_packer #(.IO_W(11), .WORD_W(55), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .word_valid(word_valid[2]), .word_ready(word_ready[2]), .word_data(word_data[2]),
    .wr_valid(wr_valid[2]), .wr_ready(wr_ready[2]), .wr_data(wr_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .pack_cnt(pack_cnt[2])
  );

  function automatic void chk(input string name, input int inst, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endfunction

  task automatic timeout_fail(input string what, input int i);
    checks++;
    failures++;
    $display("FAIL timeout_%s[%0d] at %0t: no handshake within %0d cycles", what, i, $time,
             MAX_WAIT);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards / reference models and ready generators
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_sb
    localparam int W = (g == 1) ? 32 : 55;
    localparam int B = (W + 10) / 11;
    localparam bit M = (g == 2);
    localparam logic [63:0] WMASK = (64'd1 << W) - 64'd1;

    logic [10:0] part[$];   // beats accepted for the word in progress
    logic [63:0] wexp[$];   // completed words awaiting handoff
    logic [10:0] bexp[$];   // beats still to be presented by the unpack side

    initial begin : mon
      logic        ir;
      logic        wr;
      logic [63:0] acc;
      int          c;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          part.delete();
          wexp.delete();
          bexp.delete();
        end
        // pack side
        ir = !flush[g] && (wexp.size() == 0 || word_ready[g]);
        chk("word_valid", g, 64'(word_valid[g]), 64'(wexp.size() != 0));
        chk("in_ready", g, 64'(in_ready[g]), 64'(ir));
        chk("pack_cnt", g, 64'(pack_cnt[g]), 64'(part.size()));
        if (wexp.size() != 0) begin
          chk("word_data", g, 64'(word_data[g]), wexp[0]);
          if (flush[g] || word_ready[g]) void'(wexp.pop_front());
        end
        if (flush[g]) begin
          part.delete();
        end else if (rst_n && in_valid[g] && ir) begin
          part.push_back(in_data[g]);
          if (part.size() == B) begin
            acc = 64'd0;
            for (int k = 0; k < B; k++) begin
              c = M ? (B - 1 - k) : k;
              acc = acc | (64'(part[k]) << (c * 11));
            end
            wexp.push_back(acc & WMASK);
            part.delete();
          end
        end
        // unpack side
        wr = !flush[g] && (bexp.size() == 0 || (out_ready[g] && bexp.size() == 1));
        chk("out_valid", g, 64'(out_valid[g]), 64'(bexp.size() != 0));
        chk("wr_ready", g, 64'(wr_ready[g]), 64'(wr));
        if (bexp.size() != 0) begin
          chk("out_data", g, 64'(out_data[g]), 64'(bexp[0]));
          if (flush[g]) bexp.delete();
          else if (out_ready[g]) void'(bexp.pop_front());
        end
        if (rst_n && wr_valid[g] && wr) begin
          for (int k = 0; k < B; k++) begin
            c = M ? (B - 1 - k) : k;
            bexp.push_back(11'((64'(wr_data[g]) & WMASK) >> (c * 11)));
          end
        end
      end
    end

    // Ready inputs update at +2 so a mode change made at +1 takes effect this cycle.
    initial begin : rdy
      forever begin
        @(posedge clk);
        #2;
        word_ready[g] = (pr_mode[g] == 0) ? 1'b1 :
                        (pr_mode[g] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        out_ready[g]  = (ur_mode[g] == 0) ? 1'b1 :
                        (ur_mode[g] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at posedge+1, return at posedge+1 after the handshake edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int i, input logic [10:0] d);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(negedge clk);
    while (!in_ready[i] && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) timeout_fail("in", i);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [54:0] d);
    int n;
    n = 0;
    wr_valid[i] = 1'b1;
    wr_data[i]  = d;
    @(negedge clk);
    while (!wr_ready[i] && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready[i]) timeout_fail("wr", i);
    @(posedge clk);
    #1;
    wr_valid[i] = 1'b0;
  endtask

  task automatic rand_traffic(input int i);
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          send_beat(i, 11'($urandom));
          idle($urandom_range(0, 2));
        end
      end
      begin
        for (int n = 0; n < 12; n++) begin
          logic [63:0] r;
          r = {$urandom, $urandom};
          send_word(i, r[54:0]);
          idle($urandom_range(0, 3));
        end
      end
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          flush[i] = ($urandom_range(0, 39) == 0);
        end
        flush[i] = 1'b0;
      end
    join
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [10:0] trunc_beats [3];
    logic [63:0] r;
    time         t0;
    trunc_beats[0] = 11'h7FF;
    trunc_beats[1] = 11'h7FF;
    trunc_beats[2] = 11'h3FF;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush[i]      = 1'b0;
      in_valid[i]   = 1'b0;
      in_data[i]    = '0;
      wr_valid[i]   = 1'b0;
      wr_data[i]    = '0;
      word_ready[i] = 1'b1;
      out_ready[i]  = 1'b1;
      pr_mode[i]    = 0;
      ur_mode[i]    = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_word_data", i, 64'(word_data[i]), 64'd0);
      chk("rst_out_data", i, 64'(out_data[i]), 64'd0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pack: one-cycle word_valid pulse with the expected layout.
    for (int k = 1; k <= 5; k++) send_beat(0, 11'(k));
    chk("basic_valid", 0, 64'(word_valid[0]), 64'd1);
    chk("basic_data", 0, 64'(word_data[0]), 64'h5008_00C0_1001);
    idle(1);
    chk("basic_pulse", 0, 64'(word_valid[0]), 64'd0);

    // Backpressure: held word blocks beats, then a 10-beat stream packs two words.
    pr_mode[0] = 2;
    for (int k = 0; k < 5; k++) send_beat(0, 11'($urandom));
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 0, 64'(in_ready[0]), 64'd0);
      chk("bp_word_valid", 0, 64'(word_valid[0]), 64'd1);
    end
    @(posedge clk);
    #1;
    pr_mode[0] = 0;
    for (int k = 0; k < 10; k++) send_beat(0, 11'($urandom));
    idle(2);

    // Flush mid-word drops the partial word.
    send_beat(0, 11'h123);
    send_beat(0, 11'h456);
    chk("pre_flush_cnt", 0, 64'(pack_cnt[0]), 64'd2);
    flush[0] = 1'b1;
    idle(1);
    flush[0] = 1'b0;
    chk("flush_cnt", 0, 64'(pack_cnt[0]), 64'd0);
    chk("flush_valid", 0, 64'(word_valid[0]), 64'd0);
    for (int k = 0; k < 5; k++) send_beat(0, 11'h7FF);
    chk("flush_word", 0, 64'(word_data[0]), 64'h7F_FFFF_FFFF_FFFF);
    idle(2);

    // Truncation with WORD_W=32.
    for (int k = 0; k < 3; k++) send_beat(1, 11'h7FF);
    chk("trunc_word", 1, 64'(word_data[1]), 64'hFFFF_FFFF);
    send_word(1, 55'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      chk("trunc_beat", 1, 64'(out_data[1]), 64'(trunc_beats[k]));
      idle(1);
    end
    idle(2);

    // MSB-first unpack, second word accepted during the last beat.
    send_word(2, 55'h5008_00C0_1001);
    t0 = $time;
    chk("msb_first_beat", 2, 64'(out_data[2]), 64'h005);
    r = {$urandom, $urandom};
    send_word(2, r[54:0]);
    chk("msb_b2b_cycles", 2, 64'(($time - t0) / 10), 64'd5);
    idle(8);

    // Reset during a partial pack and an in-progress unpack.
    for (int k = 0; k < 3; k++) send_beat(0, 11'($urandom));
    r = {$urandom, $urandom};
    send_word(0, r[54:0]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cnt", 0, 64'(pack_cnt[0]), 64'd0);
    chk("mid_rst_word_data", 0, 64'(word_data[0]), 64'd0);
    chk("mid_rst_out_data", 0, 64'(out_data[0]), 64'd0);
    chk("mid_rst_out_valid", 0, 64'(out_valid[0]), 64'd0);
    chk("mid_rst_wr_ready", 0, 64'(wr_ready[0]), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(0, 11'($urandom));
    chk("post_rst_cnt", 0, 64'(pack_cnt[0]), 64'd1);
    for (int k = 0; k < 4; k++) send_beat(0, 11'($urandom));
    idle(2);

    // Randomized concurrent traffic on all instances with random backpressure and flush.
    for (int i = 0; i < 3; i++) begin
      pr_mode[i] = 1;
      ur_mode[i] = 1;
    end
    fork
      rand_traffic(0);
      rand_traffic(1);
      rand_traffic(2);
    join
    for (int i = 0; i < 3; i++) begin
      pr_mode[i] = 0;
      ur_mode[i] = 0;
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
